// File: rtl/shifter_pkg.sv
// ---------------------------------------------------------------------------
// shifter_pkg
// Shared types and helpers for the pipelined log-shifter (pipe_shifter).
//   shift_op_e : 3-bit operation code carried through the pipeline.
//                Codes 101..111 are not operations; they pass the operand
//                through unchanged.
//   shw_of()   : number of shift-amount bits (and layers) for a data width.
// Optional feature macro: PIPE_SHIFTER_ROTATE_EN (used by shift_layers).
// ---------------------------------------------------------------------------
package shifter_pkg;

  typedef enum logic [2:0] {
    OP_SLL = 3'b000,
    OP_SRL = 3'b001,
    OP_SRA = 3'b010,
    OP_ROL = 3'b011,
    OP_ROR = 3'b100
  } shift_op_e;

  // One layer per shift-amount bit: layer j shifts by 2^j.
  function automatic int shw_of(input int xlen);
    return $clog2(xlen);
  endfunction

endpackage

// File: rtl/shift_layers.sv
// ---------------------------------------------------------------------------
// shift_layers
// Combinational slice of the log-shifter. Applies layers LO..HI (inclusive)
// to i_data; layer j shifts by 2^j when i_shamt[j] is set. Layers outside
// LO..HI are bypassed, so an empty range (HI < LO) is a plain pass-through.
//
// Ports:
//   i_op     in   shift_op_e   operation
//   i_data   in   XLEN         data entering this slice
//   i_shamt  in   SHW          full shift amount (only bits LO..HI used here)
//   o_data   out  XLEN         data leaving this slice
//
// Macro PIPE_SHIFTER_ROTATE_EN: when defined, ROL/ROR wrap bits from the
// opposite end; when undefined, those codes pass data through and no wrap
// logic is built.
// ---------------------------------------------------------------------------
module shift_layers
  import shifter_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int LO   = 0,
  parameter int HI   = 0
) (
  input  shift_op_e                i_op,
  input  logic [XLEN-1:0]          i_data,
  input  logic [$clog2(XLEN)-1:0]  i_shamt,
  output logic [XLEN-1:0]          o_data
);

  localparam int SHW = shw_of(XLEN);

  // Single layer by a fixed power-of-two amount (1 <= amt <= XLEN/2).
  // For SRA the top bit of any intermediate value is still the original
  // sign bit, so filling with d[XLEN-1] replicates src[XLEN-1].
  function automatic logic [XLEN-1:0] layer(input shift_op_e op,
                                            input logic [XLEN-1:0] d,
                                            input int amt);
    logic [XLEN-1:0] r;
    r = d;
    case (op)
      OP_SLL:  r = d << amt;
      OP_SRL:  r = d >> amt;
      OP_SRA:  r = $signed(d) >>> amt;
`ifdef PIPE_SHIFTER_ROTATE_EN
      OP_ROL:  r = (d << amt) | (d >> (XLEN - amt));
      OP_ROR:  r = (d >> amt) | (d << (XLEN - amt));
`endif
      default: r = d;
    endcase
    return r;
  endfunction

  logic [XLEN-1:0] w_acc;
  logic [SHW-1:0]  w_sh;

  // Walk the shift amount LSB first; the loop fully unrolls into a chain of
  // fixed-amount muxes, one per owned layer.
  always_comb begin
    w_acc = i_data;
    w_sh  = i_shamt;
    for (int j = 0; j < SHW; j++) begin
      if (j >= LO && j <= HI && w_sh[0]) begin
        w_acc = layer(i_op, w_acc, 1 << j);
      end
      w_sh = w_sh >> 1;
    end
  end

  assign o_data = w_acc;

endmodule

// File: rtl/pipe_shifter.sv
// ---------------------------------------------------------------------------
// pipe_shifter
// Pipelined log-shifter for the EX stage. SLL/SRL/SRA always, ROL/ROR when
// built with PIPE_SHIFTER_ROTATE_EN. Latency is STAGES cycles; one op per
// cycle when out_ready is held high; results leave in issue order.
//
// Parameters:
//   XLEN    data width (power of two, 8..64)
//   STAGES  pipeline register stages (1..$clog2(XLEN)), latency = STAGES
//   TAG_W   width of the opaque tag carried with each op
//
// Ports:
//   clk        in   1      clock, all state on rising edge
//   rst        in   1      synchronous reset, active-high
//   flush      in   1      discard every in-flight op and the current input
//   in_valid   in   1      request valid
//   in_ready   out  1      request accepted when in_valid && in_ready
//   in_op      in   3      shift_op_e code (101..111 pass through)
//   in_src     in   XLEN   operand
//   in_shamt   in   SHW    shift amount, SHW = $clog2(XLEN)
//   in_tag     in   TAG_W  passthrough tag
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts when out_valid && out_ready
//   out_data   out  XLEN   shifted result
//   out_tag    out  TAG_W  tag of the result
//
// Macro PIPE_SHIFTER_ROTATE_EN: enables ROL/ROR (see shift_layers).
// ---------------------------------------------------------------------------
module pipe_shifter
  import shifter_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_op,
  input  logic [XLEN-1:0]          in_src,
  input  logic [$clog2(XLEN)-1:0]  in_shamt,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_data,
  output logic [TAG_W-1:0]         out_tag
);

  localparam int SHW = shw_of(XLEN);
  // Layers owned by each stage; trailing stages may own none when SHW is
  // not a multiple of STAGES.
  localparam int LPS = (SHW + STAGES - 1) / STAGES;

  typedef struct packed {
    logic              valid;
    shift_op_e         op;
    logic [XLEN-1:0]   data;
    logic [SHW-1:0]    shamt;
    logic [TAG_W-1:0]  tag;
  } stage_t;

  stage_t             r_stage [STAGES];
  stage_t             w_src   [STAGES];
  stage_t             w_next  [STAGES];
  logic [STAGES-1:0]  w_take;

  // Stage gi shifts whatever feeds it (the input port or the previous
  // register) by its own layers and presents the result to its register.
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int LO = gi * LPS;
    localparam int HI = ((((gi + 1) * LPS) < SHW) ? ((gi + 1) * LPS) : SHW) - 1;

    logic [XLEN-1:0] w_shifted;

    if (gi == 0) begin : g_head
      assign w_src[gi] = '{valid: in_valid,
                           op:    shift_op_e'(in_op),
                           data:  in_src,
                           shamt: in_shamt,
                           tag:   in_tag};
    end else begin : g_body
      assign w_src[gi] = r_stage[gi-1];
    end

    shift_layers #(
      .XLEN (XLEN),
      .LO   (LO),
      .HI   (HI)
    ) u_layers (
      .i_op    (w_src[gi].op),
      .i_data  (w_src[gi].data),
      .i_shamt (w_src[gi].shamt),
      .o_data  (w_shifted)
    );

    assign w_next[gi] = '{valid: w_src[gi].valid,
                          op:    w_src[gi].op,
                          data:  w_shifted,
                          shamt: w_src[gi].shamt,
                          tag:   w_src[gi].tag};
  end

  // Backpressure ripples from the output back to the input: a stage can
  // take new content when it is empty or its content moves on this edge.
  // No skid buffer, so in_ready is combinational through to out_ready.
  always_comb begin
    logic drain;
    w_take = '0;
    drain  = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_take[k] = !r_stage[k].valid || drain;
      drain     = w_take[k];
    end
  end

  // Flush only kills valid bits; the payload left behind is never observed
  // as valid. Reset additionally zeroes the payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_stage[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (flush) begin
          r_stage[k].valid <= 1'b0;
        end else if (w_take[k]) begin
          r_stage[k] <= w_next[k];
        end
      end
    end
  end

  assign in_ready  = w_take[0];
  assign out_valid = r_stage[STAGES-1].valid;
  assign out_data  = r_stage[STAGES-1].data;
  assign out_tag   = r_stage[STAGES-1].tag;

endmodule

// File: tb/tb_pipe_shifter.sv
`timescale 1ns/1ps
module tb_pipe_shifter;
  import shifter_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [2:0]  in_op = 3'd0;
  logic [31:0] in_src = 32'd0;
  logic [4:0]  in_shamt = 5'd0;
  logic [4:0]  in_tag = 5'd0;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [4:0]  out_tag;

  logic        a1_in_ready, a1_out_valid, a5_in_ready, a5_out_valid;
  logic [31:0] a1_out_data, a5_out_data;
  logic [4:0]  a1_out_tag, a5_out_tag;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipe_shifter #(.XLEN(32), .STAGES(2), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_src(in_src),
    .in_shamt(in_shamt), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
  );

  // Extra depths share the stimulus with an always-ready consumer.
  pipe_shifter #(.XLEN(32), .STAGES(1), .TAG_W(5)) dut_s1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(a1_in_ready), .in_op(in_op), .in_src(in_src),
    .in_shamt(in_shamt), .in_tag(in_tag),
    .out_valid(a1_out_valid), .out_ready(1'b1), .out_data(a1_out_data), .out_tag(a1_out_tag)
  );

  pipe_shifter #(.XLEN(32), .STAGES(5), .TAG_W(5)) dut_s5 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(a5_in_ready), .in_op(in_op), .in_src(in_src),
    .in_shamt(in_shamt), .in_tag(in_tag),
    .out_valid(a5_out_valid), .out_ready(1'b1), .out_data(a5_out_data), .out_tag(a5_out_tag)
  );

  // Whole-amount reference, independent of any layer decomposition.
  function automatic logic [31:0] ref_shift(input logic [2:0] op, input logic [31:0] s,
                                            input logic [4:0] sh);
    case (op)
      3'd0: return s << sh;
      3'd1: return s >> sh;
      3'd2: return 32'($signed(s) >>> sh);
`ifdef PIPE_SHIFTER_ROTATE_EN
      3'd3: begin
        logic [63:0] d;
        d = {s, s} << sh;
        return d[63:32];
      end
      3'd4: begin
        logic [63:0] d;
        d = {s, s} >> sh;
        return d[31:0];
      end
`endif
      default: return s;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] s,
                       input logic [4:0] sh, input logic [4:0] t);
    in_valid = v; in_op = op; in_src = s; in_shamt = sh; in_tag = t;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboards for the STAGES=1 and STAGES=5 copies -------
  typedef struct { logic [31:0] data; logic [4:0] tag; } exp_t;
  exp_t q1[$];
  exp_t q5[$];
  exp_t e_push, e1, e5;

  always @(posedge clk) begin
    if (rst || flush) begin
      q1.delete();
      q5.delete();
    end else if (in_valid) begin
      e_push.data = ref_shift(in_op, in_src, in_shamt);
      e_push.tag  = in_tag;
      if (a1_in_ready) q1.push_back(e_push);
      if (a5_in_ready) q5.push_back(e_push);
    end
  end

  always @(negedge clk) begin
    if (!rst && a1_out_valid === 1'b1) begin
      if (q1.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL s1_extra: got 0x%08h expected no result", a1_out_data);
      end else begin
        e1 = q1.pop_front();
        check("s1_data", a1_out_data, e1.data);
        check("s1_tag", {27'd0, a1_out_tag}, {27'd0, e1.tag});
      end
    end
    if (!rst && a5_out_valid === 1'b1) begin
      if (q5.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL s5_extra: got 0x%08h expected no result", a5_out_data);
      end else begin
        e5 = q5.pop_front();
        check("s5_data", a5_out_data, e5.data);
        check("s5_tag", {27'd0, a5_out_tag}, {27'd0, e5.tag});
      end
    end
  end

  // ---------------- directed vector table ----------------------------------
  typedef struct {
    logic [2:0]  op;
    logic [31:0] src;
    logic [4:0]  sh;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;
  localparam int NV = 17;
  vec_t vecs[NV];

  initial begin
    logic [31:0] b_src[8];
    logic [2:0]  b_op[8];
    logic [4:0]  b_sh[8];
    logic [31:0] a_exp, b_exp;
    int got, first_c, last_c, gaps, seen;

    vecs[0]  = '{3'd0, 32'h0000_0001, 5'd31, 5'd3,  32'h8000_0000};
    vecs[1]  = '{3'd2, 32'h8000_0000, 5'd4,  5'd4,  32'hF800_0000};
    vecs[2]  = '{3'd1, 32'h8000_0000, 5'd4,  5'd5,  32'h0800_0000};
    vecs[3]  = '{3'd2, 32'h8000_0000, 5'd0,  5'd6,  32'h8000_0000};
    vecs[4]  = '{3'd2, 32'h8000_0000, 5'd31, 5'd7,  32'hFFFF_FFFF};
    vecs[5]  = '{3'd1, 32'h8000_0000, 5'd31, 5'd8,  32'h0000_0001};
    vecs[6]  = '{3'd0, 32'h1234_5678, 5'd8,  5'd9,  32'h3456_7800};
    vecs[7]  = '{3'd1, 32'h1234_5678, 5'd12, 5'd10, 32'h0001_2345};
    vecs[8]  = '{3'd2, 32'h7FFF_FFFF, 5'd31, 5'd11, 32'h0000_0000};
    vecs[9]  = '{3'd2, 32'h8765_4321, 5'd7,  5'd12, 32'hFF0E_CA86};
    vecs[10] = '{3'd5, 32'hDEAD_BEEF, 5'd5,  5'd13, 32'hDEAD_BEEF};
    vecs[11] = '{3'd7, 32'h0000_00F1, 5'd3,  5'd14, 32'h0000_00F1};
    vecs[14] = '{3'd4, 32'h1234_5678, 5'd0,  5'd17, 32'h1234_5678};
    vecs[16] = '{3'd0, 32'hABCD_EF01, 5'd5,  5'd0,  32'h79BD_E020};
`ifdef PIPE_SHIFTER_ROTATE_EN
    vecs[12] = '{3'd4, 32'h0000_00F1, 5'd4,  5'd15, 32'h1000_000F};
    vecs[13] = '{3'd3, 32'h8000_0001, 5'd1,  5'd16, 32'h0000_0003};
    vecs[15] = '{3'd3, 32'h0F00_0000, 5'd8,  5'd31, 32'h0000_000F};
`else
    vecs[12] = '{3'd4, 32'h0000_00F1, 5'd4,  5'd15, 32'h0000_00F1};
    vecs[13] = '{3'd3, 32'h8000_0001, 5'd1,  5'd16, 32'h8000_0001};
    vecs[15] = '{3'd3, 32'h0F00_0000, 5'd8,  5'd31, 32'h0F00_0000};
`endif

    // ---- reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_tag", {27'd0, out_tag}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    tick();

    // ---- table vectors, one op at a time, latency 2
    for (int i = 0; i < NV; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].src, vecs[i].sh, vecs[i].tag);
      tick();
      drive(1'b0, 3'd0, 32'd0, 5'd0, 5'd0);
      @(negedge clk);
      check("vec_latency", {31'd0, out_valid}, 32'd0);
      tick();
      @(negedge clk);
      check("vec_valid", {31'd0, out_valid}, 32'd1);
      check("vec_data", out_data, vecs[i].exp);
      check("vec_tag", {27'd0, out_tag}, {27'd0, vecs[i].tag});
      $display("vec %0d op=%0d src=0x%08h sh=%0d tag=%0d -> data=0x%08h tag=%0d",
               i, vecs[i].op, vecs[i].src, vecs[i].sh, vecs[i].tag, out_data, out_tag);
      tick();
    end

    // ---- back-to-back 8 ops, full throughput, strict order
    for (int i = 0; i < 8; i++) begin
      b_src[i] = $urandom;
      b_op[i]  = 3'($urandom_range(0, 4));
      b_sh[i]  = 5'($urandom_range(0, 31));
    end
    got = 0; first_c = -1; last_c = -1; gaps = 0;
    for (int c = 0; c < 14; c++) begin
      if (c < 8) drive(1'b1, b_op[c], b_src[c], b_sh[c], 5'(c + 20));
      else       drive(1'b0, 3'd0, 32'd0, 5'd0, 5'd0);
      @(negedge clk);
      if (c < 8) check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
      if (out_valid) begin
        if (got < 8) begin
          check("b2b_data", out_data, ref_shift(b_op[got], b_src[got], b_sh[got]));
          check("b2b_tag", {27'd0, out_tag}, 32'(got + 20));
          $display("b2b %0d op=%0d src=0x%08h sh=%0d -> 0x%08h", got, b_op[got], b_src[got],
                   b_sh[got], out_data);
        end
        if (first_c < 0) first_c = c;
        else if (c != last_c + 1) gaps++;
        last_c = c;
        got++;
      end
      tick();
    end
    check("b2b_count", 32'(got), 32'd8);
    check("b2b_first_cycle", 32'(first_c), 32'd2);
    check("b2b_gaps", 32'(gaps), 32'd0);

    // ---- stall with pipe full: in_ready drops after two accepts
    out_ready = 1'b0;
    a_exp = ref_shift(3'd0, 32'h0000_0F0F, 5'd4);
    b_exp = ref_shift(3'd2, 32'hF000_1234, 5'd8);
    for (int c = 0; c < 5; c++) begin
      if (c == 0)      drive(1'b1, 3'd0, 32'h0000_0F0F, 5'd4, 5'd1);
      else if (c == 1) drive(1'b1, 3'd2, 32'hF000_1234, 5'd8, 5'd2);
      else             drive(1'b1, 3'd1, 32'hCAFE_0000, 5'd1, 5'd3);
      @(negedge clk);
      check("stall_in_ready", {31'd0, in_ready}, (c < 2) ? 32'd1 : 32'd0);
      if (c >= 2) begin
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_data", out_data, a_exp);
        check("stall_tag", {27'd0, out_tag}, 32'd1);
      end
      $display("stall cycle %0d in_ready=%0d out_valid=%0d data=0x%08h", c, in_ready,
               out_valid, out_data);
      tick();
    end
    drive(1'b0, 3'd0, 32'd0, 5'd0, 5'd0);
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid) begin
        if (seen == 0) begin
          check("drain_a_data", out_data, a_exp);
          check("drain_a_tag", {27'd0, out_tag}, 32'd1);
        end else if (seen == 1) begin
          check("drain_b_data", out_data, b_exp);
          check("drain_b_tag", {27'd0, out_tag}, 32'd2);
        end
        seen++;
      end
      tick();
    end
    check("drain_count", 32'(seen), 32'd2);

    // ---- flush with two ops in flight plus a third presented
    out_ready = 1'b0;
    drive(1'b1, 3'd0, 32'h1111_1111, 5'd1, 5'd4);
    tick();
    drive(1'b1, 3'd1, 32'h2222_2222, 5'd2, 5'd5);
    tick();
    drive(1'b1, 3'd2, 32'h3333_3333, 5'd3, 5'd6);
    flush = 1'b1;
    @(negedge clk);
    check("preflush_valid", {31'd0, out_valid}, 32'd1);
    tick();
    flush = 1'b0;
    drive(1'b0, 3'd0, 32'd0, 5'd0, 5'd0);
    out_ready = 1'b1;
    @(negedge clk);
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("flush_no_results", 32'(seen), 32'd0);
    $display("flush with 2 in flight: results after flush=%0d", seen);

    // ---- flush drops an input even while in_ready=1
    tick();
    drive(1'b1, 3'd0, 32'h0000_00AA, 5'd1, 5'd7);
    flush = 1'b1;
    @(negedge clk);
    check("flush_empty_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    flush = 1'b0;
    drive(1'b0, 3'd0, 32'd0, 5'd0, 5'd0);
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
      tick();
    end
    check("flush_drop_input", 32'(seen), 32'd0);

    // ---- reset mid-operation discards in-flight ops and zeroes outputs
    out_ready = 1'b0;
    drive(1'b1, 3'd0, 32'h0000_0055, 5'd2, 5'd9);
    tick();
    drive(1'b1, 3'd1, 32'h5500_0000, 5'd2, 5'd10);
    tick();
    drive(1'b0, 3'd0, 32'd0, 5'd0, 5'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_data", out_data, 32'd0);
    check("midrst_tag", {27'd0, out_tag}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midrst_no_results", 32'(seen), 32'd0);
    tick();

    // ---- random stream with gaps, checked on the STAGES=1/5 copies
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) != 0)
        drive(1'b1, 3'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 31)), 5'(i));
      else
        drive(1'b0, 3'd0, 32'd0, 5'd0, 5'd0);
      tick();
    end
    drive(1'b0, 3'd0, 32'd0, 5'd0, 5'd0);
    repeat (8) tick();
    @(negedge clk);
    check("s1_queue_empty", 32'(q1.size()), 32'd0);
    check("s5_queue_empty", 32'(q5.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
